boot_sequencer: RTL and testbench
=================================

// Module: boot_sequencer
// PURPOSE
//  Power-up/button sequencer for the CADR support logic. Drives the clock-DCM reset,
//  waits for lock, holds the CPU in reset, issues a boot pulse, then tracks run/halt.
//  Converts the four front-panel buttons into sequenced requests.
//  Sits between the board buttons/DCM and the CPU reset, boot, halt and interrupt inputs.
// PARAMETERS
//  DCM_RST_CYCLES   16     cycles dcm_reset is held high per attempt
//  LOCK_TIMEOUT     4096   cycles to wait for lock before retrying the DCM reset
//  CPU_RST_CYCLES   64     cycles cpu_reset is held after lock
//  BOOT_CYCLES      8      width of the boot pulse, in cycles
//  DEBOUNCE_CYCLES  20000  cycles a button must be stable (DEBOUNCE_EN only)
// PORTS
//  sysclk      in   1  single system clock
//  reset       in   1  asynchronous, active-high reset
//  button_r    in   1  reset button, async: requests the full sequence
//  button_b    in   1  boot button, async: requests a CPU reset and boot
//  button_h    in   1  halt button, async: toggles run/halt
//  button_c    in   1  console/interrupt button, async
//  dcm_locked  in   1  DCM lock indicator, async
//  dcm_reset   out  1  reset to the DCM
//  cpu_reset   out  1  reset to the CPU
//  boot        out  1  boot strobe to the CPU
//  halt        out  1  halt level to the CPU
//  interrupt   out  1  one-cycle interrupt pulse
//  seq_state   out  3  current state, for debug
// BEHAVIOUR
//  Input synchronisation
//  - All button and dcm_locked inputs pass through a 2-flop synchroniser.
//  - A button event is a rising edge of the synchronised (or debounced) level.
//  - Holding a button produces exactly one event.
//  States: DCMRST=0, LOCK=1, CPURST=2, BOOT=3, RUN=4, HALT=5. Codes 6 and 7 go to DCMRST.
//  Reset value
//  - While reset is high: state DCMRST, counter loaded with DCM_RST_CYCLES.
//  - Outputs: dcm_reset=1, cpu_reset=1, boot=0, halt=0, interrupt=0.
//  Transitions
//  - DCMRST: after DCM_RST_CYCLES cycles, go to LOCK.
//  - LOCK: when synced dcm_locked=1, go to CPURST. After LOCK_TIMEOUT cycles with no lock,
//    go back to DCMRST (retries without limit).
//  - CPURST: after CPU_RST_CYCLES cycles, go to BOOT.
//  - BOOT: after BOOT_CYCLES cycles, go to RUN.
//  - RUN: h event goes to HALT. c event gives interrupt=1 for exactly 1 cycle.
//  - HALT: h event goes to RUN. c events are ignored.
//  - button_r event, from any state: go to DCMRST.
//  - Loss of synced dcm_locked in CPURST, BOOT, RUN or HALT: go to DCMRST.
//  - button_b event in RUN or HALT: go to CPURST. Ignored in DCMRST, LOCK, CPURST, BOOT.
//  Output decode (registered from next-state, so outputs align with seq_state)
//  - dcm_reset=1 only in DCMRST.
//  - cpu_reset=1 in DCMRST, LOCK and CPURST.
//  - boot=1 only in BOOT, with cpu_reset=0.
//  - halt=1 only in HALT.
//  Simultaneous events in one cycle, highest priority first:
//  - r, then lock loss, then b, then h, then c. Lower-priority events in that cycle are dropped.
//  Counter
//  - One shared down-counter, width $clog2 of the largest count parameter plus 1.
//  - Reloaded on every state entry. Never wraps; it holds at 0.
//  Reset mid-sequence: asserting reset in any state returns to the reset values immediately.
// CONFIGURATION
//  - DEBOUNCE_EN defined: each synchronised button must hold a level for DEBOUNCE_CYCLES
//    before that level is accepted. Glitches shorter than that produce no event.
//  - DEBOUNCE_EN undefined: the synchroniser output is used directly. Event latency is
//    3 cycles from the button edge.
// STRUCTURE
//  - Package boot_seq_pkg: state encodings, the ST_W=3 constant, and a function returning
//    the maximum counter width.
//  - Sub-module button_debounce, instantiated 4x: synchroniser, optional debounce, and a
//    rising-edge pulse out.
//  - The top level holds the FSM, the counter and the output registers.
// TESTING
//  Bench parameters: DCM_RST=4, LOCK_TIMEOUT=32, CPU_RST=8, BOOT=2, DEBOUNCE=4.
//  1. Release reset, raise dcm_locked at cycle 10.
//     -> dcm_reset high for 4 cycles; cpu_reset falls after 8 cycles in CPURST;
//        boot high for 2 cycles; then RUN (state 4).
//  2. dcm_locked held at 0.
//     -> DCMRST/LOCK cycle repeats every 36 cycles; cpu_reset stays 1.
//  3. In RUN, press h, then c, then h.
//     -> halt=1 and state 5; c gives no interrupt; second h gives halt=0.
//     Then press c -> exactly one interrupt cycle.
//  4. In RUN, raise b and r in the same cycle.
//     -> DCMRST taken (r wins); dcm_reset=1.
//  5. In RUN, drop dcm_locked for 3 cycles.
//     -> DCMRST; full sequence repeats once lock returns.
//  6. Apply a 2-cycle glitch on button_h with DEBOUNCE_EN defined.
//     -> no halt. Same glitch without DEBOUNCE_EN -> halt=1.

Source files
------------

// File: rtl/boot_seq_pkg.sv
// Shared state encoding and sizing helpers for the CADR boot sequencer.
package boot_seq_pkg;

  localparam int unsigned ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    StDcmRst = 3'd0,
    StLock   = 3'd1,
    StCpuRst = 3'd2,
    StBoot   = 3'd3,
    StRun    = 3'd4,
    StHalt   = 3'd5
  } seq_state_e;

  // Width that holds the largest phase count with one bit of headroom.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser and rising-edge detector for one asynchronous button.
// With DEBOUNCE_EN defined, a level must persist DebounceCycles cycles before it is accepted.
module button_debounce #(
  parameter int unsigned DebounceCycles = 20000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic event_o
);

`ifdef DEBOUNCE_EN
  localparam bit UseFilter = 1'b1;
`else
  localparam bit UseFilter = 1'b0;
`endif

  logic [1:0] sync_q;
  logic       level;
  logic       prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      prev_q <= level;
    end
  end

  if (UseFilter && DebounceCycles > 1) begin : g_filter
    localparam int unsigned CntW = $clog2(DebounceCycles);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            stable_q, stable_d;

    // Any sample that agrees with the accepted level restarts the stability count.
    always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync_q[1] != stable_q) begin
        if (cnt_q == CntW'(DebounceCycles - 1)) begin
          stable_d = sync_q[1];
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt_q    <= '0;
        stable_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        stable_q <= stable_d;
      end
    end

    assign level = stable_q;
  end else begin : g_bypass
    assign level = sync_q[1];
  end

  assign event_o = level & ~prev_q;

endmodule

// File: rtl/boot_sequencer.sv
// Power-up / front-panel sequencer: DCM reset, lock wait, CPU reset, boot pulse, run/halt.
// Define DEBOUNCE_EN to filter the four buttons before edge detection.
module boot_sequencer
  import boot_seq_pkg::*;
#(
  parameter int unsigned DCM_RST_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT    = 4096,
  parameter int unsigned CPU_RST_CYCLES  = 64,
  parameter int unsigned BOOT_CYCLES     = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic            sysclk,
  input  logic            reset,
  input  logic            button_r,
  input  logic            button_b,
  input  logic            button_h,
  input  logic            button_c,
  input  logic            dcm_locked,
  output logic            dcm_reset,
  output logic            cpu_reset,
  output logic            boot,
  output logic            halt,
  output logic            interrupt,
  output logic [ST_W-1:0] seq_state
);

  localparam int unsigned CntW =
      cnt_width(DCM_RST_CYCLES, LOCK_TIMEOUT, CPU_RST_CYCLES, BOOT_CYCLES);

  logic ev_r, ev_b, ev_h, ev_c;

  button_debounce #(.DebounceCycles(DEBOUNCE_CYCLES)) u_deb_r (
    .clk_i(sysclk), .rst_i(reset), .btn_i(button_r), .event_o(ev_r));
  button_debounce #(.DebounceCycles(DEBOUNCE_CYCLES)) u_deb_b (
    .clk_i(sysclk), .rst_i(reset), .btn_i(button_b), .event_o(ev_b));
  button_debounce #(.DebounceCycles(DEBOUNCE_CYCLES)) u_deb_h (
    .clk_i(sysclk), .rst_i(reset), .btn_i(button_h), .event_o(ev_h));
  button_debounce #(.DebounceCycles(DEBOUNCE_CYCLES)) u_deb_c (
    .clk_i(sysclk), .rst_i(reset), .btn_i(button_c), .event_o(ev_c));

  seq_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      lock_sync_q;
  logic            locked, expired, lock_needed, load;
  logic            dcm_reset_q, cpu_reset_q, boot_q, halt_q, irq_q, irq_d;

  assign locked      = lock_sync_q[1];
  assign expired     = (cnt_q <= CntW'(1));
  assign lock_needed = state_q inside {StCpuRst, StBoot, StRun, StHalt};

  // Priority: r, lock loss, b, h, c; anything below the winner is dropped.
  always_comb begin
    state_d = state_q;
    irq_d   = 1'b0;
    load    = 1'b0;
    if (ev_r) begin
      state_d = StDcmRst;
      load    = 1'b1;
    end else if (lock_needed && !locked) begin
      state_d = StDcmRst;
    end else begin
      case (state_q)
        StDcmRst: if (expired) state_d = StLock;
        StLock: begin
          if (locked)       state_d = StCpuRst;
          else if (expired) state_d = StDcmRst;
        end
        StCpuRst: if (expired) state_d = StBoot;
        StBoot:   if (expired) state_d = StRun;
        StRun: begin
          if (ev_b)      state_d = StCpuRst;
          else if (ev_h) state_d = StHalt;
          else if (ev_c) irq_d   = 1'b1;
        end
        StHalt: begin
          if (ev_b)      state_d = StCpuRst;
          else if (ev_h) state_d = StRun;
        end
        default: state_d = StDcmRst;
      endcase
    end
    if (state_d != state_q) load = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      case (state_d)
        StDcmRst: cnt_d = CntW'(DCM_RST_CYCLES);
        StLock:   cnt_d = CntW'(LOCK_TIMEOUT);
        StCpuRst: cnt_d = CntW'(CPU_RST_CYCLES);
        StBoot:   cnt_d = CntW'(BOOT_CYCLES);
        default:  cnt_d = '0;
      endcase
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q     <= StDcmRst;
      cnt_q       <= CntW'(DCM_RST_CYCLES);
      lock_sync_q <= '0;
      dcm_reset_q <= 1'b1;
      cpu_reset_q <= 1'b1;
      boot_q      <= 1'b0;
      halt_q      <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lock_sync_q <= {lock_sync_q[0], dcm_locked};
      dcm_reset_q <= (state_d == StDcmRst);
      cpu_reset_q <= (state_d inside {StDcmRst, StLock, StCpuRst});
      boot_q      <= (state_d == StBoot);
      halt_q      <= (state_d == StHalt);
      irq_q       <= irq_d;
    end
  end

  assign dcm_reset = dcm_reset_q;
  assign cpu_reset = cpu_reset_q;
  assign boot      = boot_q;
  assign halt      = halt_q;
  assign interrupt = irq_q;
  assign seq_state = state_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Randomised scoreboard bench for boot_sequencer: a timeline model predicts state entries
// and interrupt pulses; a monitor compares them against what the DUT presents.
module tb_boot_sequencer;

  localparam int DcmRst  = 4;
  localparam int LockTo  = 32;
  localparam int CpuRst  = 8;
  localparam int BootC   = 2;
  localparam int DebC    = 4;
  localparam int LockLat = 3;
`ifdef DEBOUNCE_EN
  localparam int Lat     = 3 + DebC;
  localparam int HoldMin = DebC;
`else
  localparam int Lat     = 3;
  localparam int HoldMin = 1;
`endif
  localparam int BtnR = 0, BtnB = 1, BtnH = 2, BtnC = 3;

  logic sysclk = 1'b0, reset = 1'b1, dcm_locked = 1'b0;
  logic button_r = 1'b0, button_b = 1'b0, button_h = 1'b0, button_c = 1'b0;
  logic dcm_reset, cpu_reset, boot, halt, interrupt;
  logic [2:0] seq_state;

  boot_sequencer #(
    .DCM_RST_CYCLES(DcmRst), .LOCK_TIMEOUT(LockTo), .CPU_RST_CYCLES(CpuRst),
    .BOOT_CYCLES(BootC), .DEBOUNCE_CYCLES(DebC)
  ) dut (
    .sysclk(sysclk), .reset(reset), .button_r(button_r), .button_b(button_b),
    .button_h(button_h), .button_c(button_c), .dcm_locked(dcm_locked),
    .dcm_reset(dcm_reset), .cpu_reset(cpu_reset), .boot(boot), .halt(halt),
    .interrupt(interrupt), .seq_state(seq_state)
  );

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  typedef struct { int st; int t; } exp_t;
  exp_t exp_q[$];
  int   irq_q[$];
  int   n_checks = 0, n_errors = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int exp_outs(input int st);
    case (st)
      0:       return 4'b1100;
      1, 2:    return 4'b0100;
      3:       return 4'b0010;
      5:       return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic push_st(input int st, input int t);
    exp_q.push_back('{st: st, t: t});
  endtask

  // CPU reset phase entered at cycle t, then boot, then run.
  task automatic cpu_seq(input int t, output int t_run);
    push_st(2, t);
    push_st(3, t + CpuRst);
    push_st(4, t + CpuRst + BootC);
    t_run = t + CpuRst + BootC;
  endtask

  // DCM reset entered at t_dcm; lock first visible to the sequencer at e_lock.
  task automatic boot_seq(input int t_dcm, input int e_lock, output int t_run);
    int  t, le;
    bit  done;
    t    = t_dcm;
    done = 1'b0;
    while (!done) begin
      le = t + DcmRst;
      push_st(1, le);
      if (e_lock <= le + LockTo) begin
        cpu_seq((e_lock > le) ? e_lock : le + 1, t_run);
        done = 1'b1;
      end else begin
        t = le + LockTo;
        push_st(0, t);
      end
    end
  endtask

  task automatic tick();
    @(negedge sysclk);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      BtnR:    button_r = v;
      BtnB:    button_b = v;
      BtnH:    button_h = v;
      default: button_c = v;
    endcase
  endtask

  task automatic press(input int which, input int hold);
    set_btn(which, 1'b1);
    repeat (hold) tick();
    set_btn(which, 1'b0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_state"}, int'(seq_state), 0);
    check({name, "_outs"}, int'({dcm_reset, cpu_reset, boot, halt, interrupt}), 5'b11000);
  endtask

  initial begin : monitor
    exp_t e;
    int   prev;
    prev = 0;
    forever begin
      @(posedge sysclk);
      #1;
      if (reset) begin
        prev = 0;
        continue;
      end
      check("outputs_decode", int'({dcm_reset, cpu_reset, boot, halt}), exp_outs(int'(seq_state)));
      if (int'(seq_state) != prev) begin
        if (exp_q.size() == 0) begin
          check("state_unexpected", int'(seq_state), prev);
        end else begin
          e = exp_q.pop_front();
          check("state_value", int'(seq_state), e.st);
          check("state_cycle", cyc, e.t);
        end
        prev = int'(seq_state);
      end
      if (interrupt) begin
        if (irq_q.size() == 0) check("interrupt_unexpected", 1, 0);
        else check("interrupt_cycle", cyc, irq_q.pop_front());
      end
    end
  end

  initial begin : stim
    int r, d, t_run, t_free, hold, which, lock_at;
    bit in_halt;

    tick();
    tick();
    check_reset_outputs("reset_hold");
    repeat (3) tick();

    // Power-up with lock arriving 10 cycles after release.
    r     = cyc;
    reset = 1'b0;
    boot_seq(r, r + 10 + LockLat, t_run);
    wait_until(r + 10);
    dcm_locked = 1'b1;

    // Halt / console buttons, including a short glitch on h.
    t_free  = t_run;
    in_halt = 1'b0;
    for (int i = 0; i < 14; i++) begin
      case (i)
        0, 2, 4: which = BtnH;
        1, 3:    which = BtnC;
        default: which = ($urandom_range(0, 1) == 1) ? BtnH : BtnC;
      endcase
      hold = (i == 4) ? 2 : int'($urandom_range(HoldMin, HoldMin + 3));
      wait_until(t_free + int'($urandom_range(0, 3)));
      d = cyc;
      if (hold >= HoldMin) begin
        if (which == BtnH) begin
          in_halt = !in_halt;
          push_st(in_halt ? 5 : 4, d + Lat);
        end else if (!in_halt) begin
          irq_q.push_back(d + Lat);
        end
      end
      press(which, hold);
      t_free = cyc + HoldMin + 2;
    end

    // Boot button from run or halt restarts at CPU reset.
    wait_until(t_free + int'($urandom_range(0, 3)));
    d = cyc;
    cpu_seq(d + Lat, t_run);
    in_halt = 1'b0;
    press(BtnB, HoldMin + 1);
    t_free = imax(cyc + HoldMin + 2, t_run);

    // b and r in the same cycle: r wins, full sequence with lock already present.
    wait_until(t_free + int'($urandom_range(0, 3)));
    d = cyc;
    push_st(0, d + Lat);
    boot_seq(d + Lat, 0, t_run);
    button_b = 1'b1;
    button_r = 1'b1;
    repeat (HoldMin + 1) tick();
    button_b = 1'b0;
    button_r = 1'b0;
    t_free = imax(cyc + HoldMin + 2, t_run);

    // Lock dropped for 3 cycles while running.
    wait_until(t_free + int'($urandom_range(0, 3)));
    d = cyc;
    push_st(0, d + LockLat);
    boot_seq(d + LockLat, d + 3 + LockLat, t_run);
    dcm_locked = 1'b0;
    repeat (3) tick();
    dcm_locked = 1'b1;
    t_free = t_run;

    // Halt, then boot from halt.
    wait_until(t_free + int'($urandom_range(0, 3)));
    d = cyc;
    push_st(5, d + Lat);
    press(BtnH, HoldMin + 1);
    t_free = cyc + HoldMin + 2;
    wait_until(t_free + int'($urandom_range(0, 3)));
    d = cyc;
    cpu_seq(d + Lat, t_run);
    press(BtnB, HoldMin + 1);

    // Asynchronous reset mid-run, then lock withheld long enough to force retries.
    wait_until(t_run + 5);
    reset      = 1'b1;
    dcm_locked = 1'b0;
    #1;
    check_reset_outputs("reset_async");
    repeat (4) tick();
    r       = cyc;
    reset   = 1'b0;
    lock_at = r + int'($urandom_range(40, 150));
    boot_seq(r, lock_at + LockLat, t_run);
    wait_until(lock_at);
    dcm_locked = 1'b1;

    t_free = t_run;
    for (int i = 0; i < 3; i++) begin
      wait_until(t_free + int'($urandom_range(0, 3)));
      d = cyc;
      irq_q.push_back(d + Lat);
      press(BtnC, int'($urandom_range(HoldMin, HoldMin + 3)));
      t_free = cyc + HoldMin + 2;
    end

    wait_until(t_free + 20);
    check("pending_states", exp_q.size(), 0);
    check("pending_interrupts", irq_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
